// File: rtl/rv_pkg.sv
// Shared types and elaboration helpers for the buffered ready-valid interface.
package rv_pkg;

  typedef enum logic { DROP_NEW = 1'b0, DROP_OLDEST = 1'b1 } overflow_policy_e;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/rv_sync_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; evict drops the head
// when full so an incoming word can take its place.
module rv_sync_fifo
  import rv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   evict,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  if (!depth_ok(DEPTH)) begin : g_depth_chk
    $error("rv_sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // A write into a full FIFO is only legal when the head leaves the same cycle.
  assign rd_en = (pop & ~empty) | (evict & full);
  assign wr_en = push & (~full | rd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rv_buffered_interface.sv
// Bidirectional buffered bridge: bus writes queue toward the device, device
// pushes queue toward the bus, each with its own FIFO and fill level.
module rv_buffered_interface #(
  parameter int WRITE_WIDTH = 8,
  parameter int READ_WIDTH  = 8,
  parameter int DEPTH       = 4,
  parameter int DROP_OLDEST = 0
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic                   READ_READY_I,
  output logic                   READ_VALID_O,
  output logic [READ_WIDTH-1:0]  READ_DATA_O,
  output logic                   WRITE_READY_O,
  input  logic                   WRITE_VALID_I,
  input  logic [WRITE_WIDTH-1:0] WRITE_DATA_I,
  input  logic                   READ_ENABLE_I,
  input  logic                   WRITE_ENABLE_I,
  output logic                   UPDATE_O,
  output logic [WRITE_WIDTH-1:0] DATA_O,
  input  logic                   ACK_I,
  input  logic                   PUSH_I,
  input  logic [READ_WIDTH-1:0]  DATA_I,
  output logic                   READ_O,
  output logic                   OVERFLOW_O,
  output logic [$clog2(DEPTH):0] RLEVEL_O,
  output logic [$clog2(DEPTH):0] WLEVEL_O
);

  localparam rv_pkg::overflow_policy_e POLICY =
    (DROP_OLDEST != 0) ? rv_pkg::DROP_OLDEST : rv_pkg::DROP_NEW;

  logic wfull, wempty, rfull, rempty;
  logic wpush, wpop, rpop, rblocked, evict, overflow_q;

  // Ready/valid depend only on enables and stored state, never on the partner handshake.
  assign WRITE_READY_O = WRITE_ENABLE_I & ~wfull;
  assign wpush         = WRITE_VALID_I & WRITE_READY_O;
  assign wpop          = ACK_I & ~wempty;
  assign UPDATE_O      = ~wempty;

  assign READ_VALID_O  = READ_ENABLE_I & ~rempty;
  assign rpop          = READ_VALID_O & READ_READY_I;
  assign READ_O        = rpop;

  assign rblocked = PUSH_I & rfull & ~rpop;
  assign evict    = rblocked & (POLICY == rv_pkg::DROP_OLDEST);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) overflow_q <= 1'b0;
    else       overflow_q <= rblocked;
  end

  assign OVERFLOW_O = overflow_q;

  rv_sync_fifo #(.WIDTH(WRITE_WIDTH), .DEPTH(DEPTH)) u_wfifo (
    .clk   (CLK_I),
    .rst   (RST_I),
    .push  (wpush),
    .pop   (wpop),
    .evict (1'b0),
    .wdata (WRITE_DATA_I),
    .rdata (DATA_O),
    .full  (wfull),
    .empty (wempty),
    .level (WLEVEL_O)
  );

  rv_sync_fifo #(.WIDTH(READ_WIDTH), .DEPTH(DEPTH)) u_rfifo (
    .clk   (CLK_I),
    .rst   (RST_I),
    .push  (PUSH_I),
    .pop   (rpop),
    .evict (evict),
    .wdata (DATA_I),
    .rdata (READ_DATA_O),
    .full  (rfull),
    .empty (rempty),
    .level (RLEVEL_O)
  );

endmodule

// File: tb/tb_rv_buffered_interface.sv
// Bench for rv_buffered_interface: both overflow policies side by side, queue model plus literal scenarios.
`timescale 1ns/1ps
module tb_rv_buffered_interface;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic read_ready = 1'b0, write_valid = 1'b0, ack = 1'b0, push = 1'b0;
  logic read_enable = 1'b1, write_enable = 1'b1;
  logic [7:0] write_data = 8'h00, data_in = 8'h00;

  logic [1:0]         read_valid, write_ready, update, read_o, overflow;
  logic [1:0][7:0]    read_data, data_out;
  logic [1:0][LW-1:0] rlevel, wlevel;

  int checks = 0;
  int failures = 0;

  // Reference state: index 0 = drop-incoming instance, 1 = drop-oldest instance.
  logic [7:0] wq[$];
  logic [7:0] rq[2][$];
  bit         ovf_exp[2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    rv_buffered_interface #(
      .WRITE_WIDTH(8), .READ_WIDTH(8), .DEPTH(DEPTH), .DROP_OLDEST(k)
    ) u_dut (
      .CLK_I          (clk),
      .RST_I          (rst),
      .READ_READY_I   (read_ready),
      .READ_VALID_O   (read_valid[k]),
      .READ_DATA_O    (read_data[k]),
      .WRITE_READY_O  (write_ready[k]),
      .WRITE_VALID_I  (write_valid),
      .WRITE_DATA_I   (write_data),
      .READ_ENABLE_I  (read_enable),
      .WRITE_ENABLE_I (write_enable),
      .UPDATE_O       (update[k]),
      .DATA_O         (data_out[k]),
      .ACK_I          (ack),
      .PUSH_I         (push),
      .DATA_I         (data_in),
      .READ_O         (read_o[k]),
      .OVERFLOW_O     (overflow[k]),
      .RLEVEL_O       (rlevel[k]),
      .WLEVEL_O       (wlevel[k])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  ws, rs;
    bit  acc, pop, full;
    ws  = wq.size();
    acc = write_enable && write_valid && (ws < DEPTH);
    if (ack && ws > 0) void'(wq.pop_front());
    if (acc) wq.push_back(write_data);
    for (int k = 0; k < 2; k++) begin
      rs   = rq[k].size();
      full = (rs == DEPTH);
      pop  = read_enable && read_ready && (rs > 0);
      ovf_exp[k] = 1'b0;
      if (pop) void'(rq[k].pop_front());
      if (push) begin
        if (!full || pop) rq[k].push_back(data_in);
        else begin
          ovf_exp[k] = 1'b1;
          if (k == 1) begin
            void'(rq[k].pop_front());
            rq[k].push_back(data_in);
          end
        end
      end
    end
  endtask

  // Compare on the falling edge; inputs change only 2ns after the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        wq.delete();
        for (int k = 0; k < 2; k++) begin
          rq[k].delete();
          ovf_exp[k] = 1'b0;
        end
      end
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m_wready%0d", k), 32'(write_ready[k]), 32'(write_enable && wq.size() < DEPTH));
        chk($sformatf("m_update%0d", k), 32'(update[k]), 32'(wq.size() > 0));
        chk($sformatf("m_wlevel%0d", k), 32'(wlevel[k]), 32'(wq.size()));
        if (wq.size() > 0) chk($sformatf("m_data_o%0d", k), 32'(data_out[k]), 32'(wq[0]));
        chk($sformatf("m_rvalid%0d", k), 32'(read_valid[k]), 32'(read_enable && rq[k].size() > 0));
        chk($sformatf("m_read_o%0d", k), 32'(read_o[k]),
            32'(read_enable && read_ready && rq[k].size() > 0));
        chk($sformatf("m_rlevel%0d", k), 32'(rlevel[k]), 32'(rq[k].size()));
        chk($sformatf("m_ovf%0d", k), 32'(overflow[k]), 32'(ovf_exp[k]));
        if (rq[k].size() > 0) chk($sformatf("m_rdata%0d", k), 32'(read_data[k]), 32'(rq[k][0]));
      end
      if (!rst) model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] wtab [5];
    logic [7:0] e;
    int         ovf_cnt [2];
    wtab = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    repeat (2) tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_rvalid", 32'(read_valid[k]), 32'd0);
      chk("rst_update", 32'(update[k]), 32'd0);
      chk("rst_wready", 32'(write_ready[k]), 32'd1);
      chk("rst_levels", 32'({rlevel[k], wlevel[k]}), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Fill the write FIFO, then offer a fifth word that must be refused.
    write_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      write_data = wtab[i];
      tick();
    end
    write_data = wtab[4];
    #1;
    chk("wfull_ready", 32'(write_ready[0]), 32'd0);
    chk("wfull_level", 32'(wlevel[0]), 32'd4);
    tick();
    chk("w5_refused_level", 32'(wlevel[0]), 32'd4);
    write_valid = 1'b0;

    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_data", 32'(data_out[0]), 32'(wtab[i]));
      chk("drain_update", 32'(update[1]), 32'd1);
      tick();
    end
    #1;
    chk("drained_update", 32'(update[0]), 32'd0);
    chk("drained_level", 32'(wlevel[0]), 32'd0);
    ack = 1'b0;

    // Overflow policy: five pushes into a disabled read channel.
    read_enable = 1'b0;
    push = 1'b1;
    ovf_cnt = '{0, 0};
    for (int i = 0; i < 5; i++) begin
      data_in = 8'hA0 + 8'(i);
      tick();
      push = (i < 4);
      #1;
      for (int k = 0; k < 2; k++) ovf_cnt[k] += int'(overflow[k]);
    end
    push = 1'b0;
    repeat (2) begin
      tick();
      #1;
      for (int k = 0; k < 2; k++) ovf_cnt[k] += int'(overflow[k]);
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ovf_pulses%0d", k), 32'(ovf_cnt[k]), 32'd1);
      chk($sformatf("ovf_rlevel%0d", k), 32'(rlevel[k]), 32'd4);
    end
    read_enable = 1'b1;
    read_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      e = 8'hA0 + 8'(i);
      chk("drop_new_data", 32'(read_data[0]), 32'(e));
      e = 8'hA1 + 8'(i);
      chk("drop_old_data", 32'(read_data[1]), 32'(e));
      chk("read_o_pulse", 32'(read_o), 32'd3);
      tick();
    end
    #1;
    chk("read_empty_valid", 32'(read_valid), 32'd0);
    read_ready = 1'b0;

    // Full read FIFO with simultaneous push and pop: no overflow, level held.
    read_enable = 1'b0;
    push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'hB0 + 8'(i);
      tick();
    end
    data_in = 8'hC0;
    read_enable = 1'b1;
    read_ready  = 1'b1;
    #1;
    chk("pp_read_o", 32'(read_o), 32'd3);
    tick();
    push = 1'b0;
    read_ready = 1'b0;
    #1;
    chk("pp_rlevel", 32'(rlevel[0]), 32'd4);
    chk("pp_head", 32'(read_data[1]), 32'hB1);
    chk("pp_ovf", 32'(overflow), 32'd0);
    read_ready = 1'b1;
    repeat (4) tick();
    read_ready = 1'b0;

    // Asynchronous reset between edges with both FIFOs partly full.
    read_enable = 1'b0;
    push = 1'b1;
    write_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 8'hD0 + 8'(i);
      write_data = 8'hE0 + 8'(i);
      write_valid = (i < 2);
      tick();
    end
    push = 1'b0;
    write_valid = 1'b0;
    read_enable = 1'b1;
    #1;
    chk("pre_rst_rlevel", 32'(rlevel[0]), 32'd3);
    chk("pre_rst_wlevel", 32'(wlevel[1]), 32'd2);
    #0.5 rst = 1'b1;
    #0.5;
    for (int k = 0; k < 2; k++) begin
      chk("async_rst_rvalid", 32'(read_valid[k]), 32'd0);
      chk("async_rst_update", 32'(update[k]), 32'd0);
      chk("async_rst_levels", 32'({rlevel[k], wlevel[k]}), 32'd0);
    end
    tick();
    rst = 1'b0;
    write_valid = 1'b1;
    write_data  = 8'h5A;
    push        = 1'b1;
    data_in     = 8'h6B;
    tick();
    write_valid = 1'b0;
    push = 1'b0;
    #1;
    chk("post_rst_data", 32'(data_out[0]), 32'h5A);
    chk("post_rst_wlevel", 32'(wlevel[0]), 32'd1);
    chk("post_rst_rdata", 32'(read_data[1]), 32'h6B);
    chk("post_rst_rvalid", 32'(read_valid), 32'd3);
    ack = 1'b1;
    read_ready = 1'b1;
    tick();
    ack = 1'b0;
    read_ready = 1'b0;

    // Randomized traffic, including occasional mid-stream resets.
    for (int n = 0; n < 3000; n++) begin
      tick();
      write_valid  = 1'($urandom_range(0, 1));
      write_data   = 8'($urandom);
      ack          = ($urandom_range(0, 3) == 0);
      push         = ($urandom_range(0, 2) != 0);
      data_in      = 8'($urandom);
      read_ready   = ($urandom_range(0, 2) == 0);
      read_enable  = ($urandom_range(0, 7) != 0);
      write_enable = ($urandom_range(0, 7) != 0);
      rst          = ($urandom_range(0, 299) == 0);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_buffered_interface.md
Name: rv_buffered_interface

Overview:
Parametrised successor to the single-entry ready-valid bus register. It buffers both directions between a system-side ready-valid bus and a device: a write FIFO runs from bus to device, and a read FIFO runs from device to bus. Each FIFO has a configurable depth. The read side has a configurable overflow policy, and both sides expose fill levels. It sits between the streaming trace buffer's control/data registers and the transport (e.g. UART/DMI) bus.

Parameters:
WRITE_WIDTH, 8, bus-to-device data width in bits
READ_WIDTH, 8, device-to-bus data width in bits
DEPTH, 4, entries per FIFO; power of two, >= 2
DROP_OLDEST, 0, read FIFO full policy: 0 = drop incoming word, 1 = evict head and accept incoming word

Ports:
CLK_I  in  1  clock
RST_I  in  1  reset, asynchronous, active-high
READ_READY_I  in  1  bus ready to take read data
READ_VALID_O  out  1  read data valid
READ_DATA_O  out  READ_WIDTH  read FIFO head
WRITE_READY_O  out  1  interface accepts write data
WRITE_VALID_I  in  1  bus write data valid
WRITE_DATA_I  in  WRITE_WIDTH  bus write data
READ_ENABLE_I  in  1  gates the bus read channel
WRITE_ENABLE_I  in  1  gates the bus write channel
UPDATE_O  out  1  write FIFO non-empty; DATA_O valid
DATA_O  out  WRITE_WIDTH  write FIFO head
ACK_I  in  1  device consumes DATA_O
PUSH_I  in  1  device pushes DATA_I
DATA_I  in  READ_WIDTH  device data to send
READ_O  out  1  pulse: bus read transfer completed this cycle
OVERFLOW_O  out  1  registered one-cycle pulse: read-side word dropped or evicted
RLEVEL_O  out  $clog2(DEPTH)+1  read FIFO occupancy
WLEVEL_O  out  $clog2(DEPTH)+1  write FIFO occupancy

Behaviour:
- Reset (RST_I high, asynchronous): all pointers 0, both FIFOs empty, OVERFLOW_O=0.
  - Resulting output values: READ_VALID_O=0, UPDATE_O=0, WRITE_READY_O=WRITE_ENABLE_I, RLEVEL_O=WLEVEL_O=0.
  - Reset mid-operation discards all contents; no partial transfer completes.
- FIFOs: first-word-fall-through.
  - Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - empty = pointers equal; full = MSBs differ and the rest are equal.
  - Level = wr_ptr - rd_ptr, modulo arithmetic.
  - A pushed word is visible at the head the cycle after the push edge.
- Write path:
  - WRITE_READY_O = WRITE_ENABLE_I & ~wfull. A word is accepted when WRITE_VALID_I & WRITE_READY_O.
  - UPDATE_O = ~wempty; DATA_O = head.
  - ACK_I & UPDATE_O pops the head. ACK_I while empty is ignored.
  - Full with simultaneous ACK: WRITE_READY_O stays low that cycle (ready does not depend on ACK_I). Ready rises the next cycle.
- Read path:
  - READ_VALID_O = READ_ENABLE_I & ~rempty; READ_DATA_O = head.
  - A bus pop occurs on READ_VALID_O & READ_READY_I. READ_O equals that pop condition, combinationally.
  - PUSH_I when not full: data is written.
  - PUSH_I when full with a bus pop in the same cycle: push and pop both occur, level is unchanged, no overflow.
  - PUSH_I when full without a pop, DROP_OLDEST=0: incoming word discarded; OVERFLOW_O pulses the next cycle.
  - PUSH_I when full without a pop, DROP_OLDEST=1: head evicted (rd_ptr advances), incoming word written, level stays DEPTH; OVERFLOW_O pulses the next cycle.
  - Push on empty with READ_READY_I high: no pop that cycle (valid is low); the word appears the next cycle.
- Enables: deasserting an enable freezes only the bus side of that channel. Device push and ACK continue. Contents are retained.
- No combinational path from READ_READY_I or WRITE_VALID_I to the ready/valid outputs of the same channel, except READ_O.

Decomposition:
- Package rv_pkg:
  - ptr_width function ($clog2(DEPTH)+1)
  - overflow_policy_e enum {DROP_NEW, DROP_OLDEST}
  - DEPTH power-of-two assertion macro/constant
- Sub-module rv_sync_fifo (WIDTH, DEPTH; push, pop, evict, data, full, empty, level). Instantiated twice:
  - write direction, evict tied 0
  - read direction, evict driven by the full & push & ~pop & DROP_OLDEST condition

Test Plan:
1. Reset, then DEPTH=4, WRITE_ENABLE_I=1: write 0x11,0x22,0x33,0x44 back-to-back, ACK_I=0 -> WRITE_READY_O low after 4th, WLEVEL_O=4; 5th word 0x55 not accepted.
2. Continue 1: ACK_I held high -> DATA_O sequence 0x11,0x22,0x33,0x44 on consecutive cycles, UPDATE_O falls after 4th, WLEVEL_O=0.
3. DROP_OLDEST=0: push 0xA0..0xA4 with READ_ENABLE_I=0 -> OVERFLOW_O one pulse, RLEVEL_O=4. Enable reads -> 0xA0,0xA1,0xA2,0xA3, with READ_O pulsing per transfer.
4. DROP_OLDEST=1: same stimulus -> one OVERFLOW_O pulse; reads return 0xA1,0xA2,0xA3,0xA4.
5. Read FIFO full, PUSH_I=1 and READ_READY_I=1 same cycle -> pop head, push new, RLEVEL_O stays 4, OVERFLOW_O=0.
6. Assert RST_I asynchronously mid-stream (between edges) with RLEVEL_O=3, WLEVEL_O=2 -> immediately READ_VALID_O=0, UPDATE_O=0, levels 0; first word after release is transferred correctly.
